// File: rtl/mult16_seq.sv
// Sequential 16-bit shift-and-add multiplier: one Add16 is reused once per RUN cycle
// to build the low 16 bits of a*b, with a start/busy/done handshake.

module add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    // Carry out of bit 15 is deliberately dropped; results wrap mod 2^16.
    assign sum = a + b;
endmodule

module mult16_seq #(
    parameter int EARLY_EXIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    // Handshake: start is sampled only while idle (busy=0); once accepted, busy stays
    // high through RUN and DONE, then done pulses for exactly one cycle with product
    // valid, and product holds until the next accepted start completes.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] m_reg, q_reg, p_reg;
    logic [15:0] sum;
    logic [4:0]  count;
    logic        last_step;

    add16 u_add (
        .a   (p_reg),
        .b   (m_reg),
        .sum (sum)
    );

    // Early exit looks at the multiplier after this cycle's shift.
    always_comb begin
        last_step = (count == 5'd15);
        if ((EARLY_EXIT != 0) && (q_reg[15:1] == 15'd0)) begin
            last_step = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            m_reg   <= 16'd0;
            q_reg   <= 16'd0;
            p_reg   <= 16'd0;
            count   <= 5'd0;
            product <= 16'd0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= a;
                        q_reg <= b;
                        p_reg <= 16'd0;
                        count <= 5'd0;
                    end
                end
                RUN: begin
                    if (q_reg[0]) p_reg <= sum;
                    m_reg <= {m_reg[14:0], 1'b0};
                    q_reg <= {1'b0, q_reg[15:1]};
                    count <= count + 5'd1;
                end
                DONE: begin
                    product <= p_reg;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mult16_seq.md
Name: mult16_seq

Overview:
- Sequential 16-bit multiplier controller built around a single Add16 instance, using shift-and-add.
- Sequences one Add16 over multiple cycles to produce the low 16 bits of a*b; the hardware equivalent of the Mult program.
- Sits beside the ALU datapath as a multi-cycle arithmetic unit with a start/busy/done handshake.

Parameters:
- EARLY_EXIT, 0, when 1 the RUN phase ends as soon as the remaining multiplier reaches zero; when 0 RUN is always 16 cycles.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  16  multiplicand; captured when start is accepted
- b  input  16  multiplier; captured when start is accepted
- product  output  16  (a*b) mod 2^16; valid from done, held until next accepted start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse marking product valid

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: state=IDLE, product=0, busy=0, done=0, internal M=Q=P=0, count=0.
- Internal registers: M (16, shifted multiplicand), Q (16, shifted multiplier), P (16, partial product), count (5 bits).
- Adder: the single addition path is an Add16 instance with a=P and b=M. P takes its output. No other adder for P.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k accepts the request: M<=a, Q<=b, P<=0, count<=0, go to RUN. start=0 keeps IDLE.
- RUN, per cycle:
  - if Q[0]=1 then P<=Add16(P,M), else P holds.
  - M<=M<<1 with zero fill; Q<=Q>>1 with zero fill; count<=count+1.
  - Carry out of bit 15 is discarded; the result wraps mod 2^16.
- RUN exit, EARLY_EXIT=0: leave RUN after the cycle where count==15, i.e. exactly 16 RUN cycles, edges k+1..k+16.
- RUN exit, EARLY_EXIT=1: leave after the current step if the next Q is zero, or count==15.
  - If b==0, RUN still performs one step.
- DONE: lasts one cycle. product<=P is registered on entry, so it is visible with done. done=1, then go to IDLE.
- Latency, EARLY_EXIT=0: start accepted at edge k; done=1 and product valid during the cycle after edge k+17; busy high for 17 cycles.
- Latency, EARLY_EXIT=1: done follows N RUN cycles, where N = max(1, index of b's highest set bit + 1).
- start while busy (RUN or DONE) is ignored and not queued. start held high continuously re-triggers on the IDLE cycle after DONE.
- a and b may change freely after acceptance and do not affect the result in progress.
- product holds its last value through IDLE. It updates only on DONE entry.
- reset mid-operation (any state) returns to reset values next edge. done never pulses for an aborted operation.
- reset and start asserted together: reset wins.

Test Plan:
- Reset, then a=3, b=5, 1-cycle start, EARLY_EXIT=0 -> busy for 17 cycles; done pulses once 17 edges after acceptance; product=15 (0x000F).
- a=0x00FF, b=0x0101 -> product=0xFFFF. Then a=0xFFFF, b=0xFFFF -> product=0x0001 (wraparound). Then a=300, b=300 -> product=0x5F90 (90000 mod 65536).
- a=0, b=0x1234 and a=0x1234, b=0 -> product=0 both times; done still pulses once each; the prior product is held until DONE.
- start=1 pulsed at RUN cycle 5 with a=9, b=9 during a 3*5 job -> ignored; product=15; no second done. start held high throughout -> back-to-back jobs, one IDLE cycle between done and the next RUN.
- reset asserted at RUN cycle 8 of a 0x1234*0x0003 job -> next cycle busy=0, done=0, product=0; a following 2*2 job yields 4 with normal latency.
- EARLY_EXIT=1, a=7, b=2 -> 2 RUN cycles; done 3 edges after acceptance; product=14. With b=0x8000 -> 16 RUN cycles; product=0x8000 for a=1.
